// File: rtl/fifo_sync_if.sv
// fifo_sync_if: handshake and status bundle between a FIFO user and fifo_sync.
// The master side issues read/write requests; the slave side (the FIFO)
// returns data and occupancy status.
// Optional build macro: FIFO_SYNC_ERR_EN adds the sticky overflow/underflow flags.
interface fifo_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                       w_enable;
    logic                       r_enable;
    logic [DATA_WIDTH-1:0]      write_data;
    logic [DATA_WIDTH-1:0]      read_data;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
`ifdef FIFO_SYNC_ERR_EN
    logic                       overflow;
    logic                       underflow;
`endif

`ifdef FIFO_SYNC_ERR_EN
    modport master (
        output w_enable, r_enable, write_data,
        input  read_data, full, empty, count, overflow, underflow
    );
    modport slave (
        input  w_enable, r_enable, write_data,
        output read_data, full, empty, count, overflow, underflow
    );
`else
    modport master (
        output w_enable, r_enable, write_data,
        input  read_data, full, empty, count
    );
    modport slave (
        input  w_enable, r_enable, write_data,
        output read_data, full, empty, count
    );
`endif
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock first-in first-out buffer with a registered read port.
// Storage is DEPTH x DATA_WIDTH with wrapping pointers; DEPTH must be a power of two.
// Optional build macro: FIFO_SYNC_ERR_EN adds sticky overflow/underflow flags,
// set by rejected writes/reads and cleared only by reset.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    fifo_sync_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

    logic full_w;
    logic empty_w;
    logic rd_accept;
    logic wr_accept;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Decide which requests are accepted and compute the next pointer/count/data state.
    always_comb begin
        rd_accept   = bus.r_enable && !empty_w;
        wr_accept   = bus.w_enable && (!full_w || rd_accept);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        read_data_d = read_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            read_data_d = mem_q[rd_ptr_q];
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state registers; reset empties the FIFO and clears the output word.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
        end
    end

    // Storage array: written on accepted writes only, never cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= bus.write_data;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.count     = count_q;

`ifdef FIFO_SYNC_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: latch any rejected write or rejected read until reset.
    always_comb begin
        overflow_d  = overflow_q  || (bus.w_enable && !wr_accept);
        underflow_d = underflow_q || (bus.r_enable && empty_w);
    end

    // Error flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed self-checking bench for fifo_sync (DATA_WIDTH=8, DEPTH=16).
// Works with or without FIFO_SYNC_ERR_EN defined.
module tb_fifo_sync;
    logic clock;
    logic reset;
    int   errorCount;
    int   checkCount;

    fifo_sync_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    fifo_sync #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its expected value and record the outcome.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, let the rising edge happen, then settle 1 unit past it.
    task automatic applyStimulus(input logic we, input logic re, input logic [7:0] wd);
        bus.w_enable   = we;
        bus.r_enable   = re;
        bus.write_data = wd;
        @(posedge clock);
        #1;
        bus.w_enable   = 1'b0;
        bus.r_enable   = 1'b0;
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        errorCount     = 0;
        checkCount     = 0;
        reset          = 1'b1;
        bus.w_enable   = 1'b0;
        bus.r_enable   = 1'b0;
        bus.write_data = '0;

        // Reset then idle.
        applyStimulus(1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("reset_empty", 32'(bus.empty), 32'd1);
        checkOutput("reset_full", 32'(bus.full), 32'd0);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_rdata", 32'(bus.read_data), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset_underflow", 32'(bus.underflow), 32'd0);
`endif

        // Write 0..4, then seven reads; the last two are ignored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(i));
        checkOutput("w5_count", 32'(bus.count), 32'd5);
        checkOutput("w5_empty", 32'(bus.empty), 32'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("r7_rdata", 32'(bus.read_data), (i < 5) ? 32'(i) : 32'd4);
            if (i == 4) checkOutput("r7_empty_after5", 32'(bus.empty), 32'd1);
        end
        checkOutput("r7_count", 32'(bus.count), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        checkOutput("r7_underflow", 32'(bus.underflow), 32'd1);
        checkOutput("r7_overflow", 32'(bus.overflow), 32'd0);
`endif

        // Fill with 1..16, reject a 17th write of 99, drain 1..16.
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, 8'(i));
        checkOutput("fill_full", 32'(bus.full), 32'd1);
        checkOutput("fill_count", 32'(bus.count), 32'd16);
        applyStimulus(1'b1, 1'b0, 8'd99);
        checkOutput("ovf_count", 32'(bus.count), 32'd16);
        checkOutput("ovf_full", 32'(bus.full), 32'd1);
        checkOutput("ovf_rdata", 32'(bus.read_data), 32'd4);
`ifdef FIFO_SYNC_ERR_EN
        checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
`endif
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("drain_rdata", 32'(bus.read_data), 32'(i));
        end
        checkOutput("drain_empty", 32'(bus.empty), 32'd1);
        checkOutput("drain_full", 32'(bus.full), 32'd0);

        // Full FIFO: simultaneous read and write of 42.
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, 8'(i + 20));
        applyStimulus(1'b1, 1'b1, 8'd42);
        checkOutput("fullrw_rdata", 32'(bus.read_data), 32'd21);
        checkOutput("fullrw_count", 32'(bus.count), 32'd16);
        checkOutput("fullrw_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("fullrw_drain", 32'(bus.read_data), (i < 15) ? 32'(i + 22) : 32'd42);
        end
        checkOutput("fullrw_empty", 32'(bus.empty), 32'd1);

        // Empty FIFO: simultaneous read and write of 7, no fall-through.
        applyStimulus(1'b1, 1'b1, 8'd7);
        checkOutput("emptyrw_rdata", 32'(bus.read_data), 32'd42);
        checkOutput("emptyrw_count", 32'(bus.count), 32'd1);
        checkOutput("emptyrw_empty", 32'(bus.empty), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("emptyrw_next", 32'(bus.read_data), 32'd7);
        checkOutput("emptyrw_count0", 32'(bus.count), 32'd0);

        // Fill ten words, reset with requests active, then write/read a new word.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(i + 50));
        checkOutput("pre_rst_count", 32'(bus.count), 32'd10);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'd77);
        reset = 1'b0;
        checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
        checkOutput("midrst_count", 32'(bus.count), 32'd0);
        checkOutput("midrst_rdata", 32'(bus.read_data), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        checkOutput("midrst_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("midrst_underflow", 32'(bus.underflow), 32'd0);
`endif
        applyStimulus(1'b1, 1'b0, 8'd88);
        checkOutput("post_rst_count", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("post_rst_rdata", 32'(bus.read_data), 32'd88);
        checkOutput("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of storage entries; a power of two, at least 2.
REQ-003 Port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port w_enable, input, 1, write request for the current cycle.
REQ-006 Port r_enable, input, 1, read request for the current cycle.
REQ-007 Port write_data, input, DATA_WIDTH, word to store when a write is accepted.
REQ-008 Port read_data, output, DATA_WIDTH, registered output word.
REQ-009 Port full, output, 1, high when the occupancy equals DEPTH.
REQ-010 Port empty, output, 1, high when the occupancy equals 0.
REQ-011 Port count, output, log2(DEPTH)+1, current occupancy in the range 0..DEPTH.

Function
REQ-012 Storage is DEPTH x DATA_WIDTH, addressed by wrapping write and read pointers; mod-DEPTH wrap-around, no gaps.
REQ-013 A write is accepted when w_enable=1 and (full=0 or a read is accepted in the same cycle); write_data is stored at the write pointer and the pointer increments.
REQ-014 A read is accepted when r_enable=1 and empty=0; the word at the read pointer is loaded into read_data on that clock edge and the pointer increments; latency is 1 cycle.
REQ-015 read_data holds its last value whenever no read is accepted.
REQ-016 A write to a full FIFO without a simultaneous read is ignored: no state change and no data corruption.
REQ-017 A read from an empty FIFO is ignored: pointers and read_data are unchanged.
REQ-018 Simultaneous read and write when not empty: both are performed and count is unchanged; when full, the write lands in the slot freed by the read.
REQ-019 Simultaneous read and write when empty: only the write is performed (no fall-through), and count becomes 1.
REQ-020 count increments on a write-only cycle, decrements on a read-only cycle, and is otherwise held.
REQ-021 full and empty are decoded combinationally from registered state, so they reflect the occupancy after the most recent edge.
REQ-022 Data ordering is strictly first-in first-out.

Reset
REQ-023 When reset=1 at a rising edge: both pointers=0, count=0, empty=1, full=0, read_data=0.
REQ-024 Reset has priority over concurrent w_enable and r_enable; a reset mid-operation discards all stored words.
REQ-025 Memory array contents are not cleared by reset.

Configuration
REQ-026 Macro FIFO_SYNC_ERR_EN, when defined, adds sticky output flags overflow and underflow (1 bit each).
- overflow is set by a rejected write (REQ-016).
- underflow is set by a rejected read (REQ-017).
- Both flags are cleared only by reset.
REQ-027 When FIFO_SYNC_ERR_EN is undefined, these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-028 Reset, then idle -> empty=1, full=0, count=0, read_data=0.
REQ-029 Write 0,1,2,3,4, then assert r_enable for 7 cycles -> read_data sequence 0,1,2,3,4; the 2 extra reads are ignored, read_data stays 4, and empty=1 after the fifth read.
REQ-030 Write 1..16 consecutively -> full=1 and count=16 after the 16th write; a 17th write with value 99 is ignored (overflow=1 if enabled); 16 reads then return 1..16 and end with empty=1.
REQ-031 With full, assert read and write (value 42) in the same cycle -> read returns the oldest word, count stays 16, and 42 emerges last.
REQ-032 With empty, assert read and write (value 7) in the same cycle -> read_data unchanged, count=1; the next read returns 7.
REQ-033 Fill 10 words, assert reset -> next cycle empty=1, count=0, read_data=0; a subsequent write then read returns the new word only.
